fifo_rd_arbiter: RTL

- Round-robin read arbiter that shares one sync FIFO read port between NUM_REQ consumers.
- Grants bursts of up to BURST_LEN pops to one requester at a time.
- Drives the FIFO's rd_ready and registers each popped word with the id of its owner.
- Sits between the sync FIFO's read side and the consumer blocks.

---
 rtl/fifo_rd_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing one show-ahead FIFO read port between NUM_REQ consumers.
// Define FIFO_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module fifo_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_ready,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_WIDTH-1:0]   out_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_reg;
    logic [ID_WIDTH-1:0]     owner_reg;
    logic [CNT_WIDTH-1:0]    burst_cnt_reg;
    logic                    out_valid_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic [ID_WIDTH-1:0]     out_id_reg;

    logic [ID_WIDTH-1:0]     rr_base;
    logic [ID_WIDTH-1:0]     win_idx;
    logic [ID_WIDTH-1:0]     cand;
    logic                    win_found;
    logic                    owner_req;
    logic                    pop;
    logic                    burst_last;
    logic                    leave_burst;

    assign owner_req   = req[owner_reg];
    assign pop         = (state_reg == BURST) && owner_req && !fifo_rd_empty;
    assign burst_last  = (burst_cnt_reg == CNT_WIDTH'(BURST_LEN - 1));
    assign leave_burst = (state_reg == BURST) && (!owner_req || (pop && burst_last));

`ifdef FIFO_ARB_FIXED_PRIO_EN
    assign rr_base = '0;
`else
    logic [ID_WIDTH-1:0] rr_ptr_reg;
    logic [ID_WIDTH-1:0] rr_next;

    // Modulo keeps the pointer legal when NUM_REQ is not a power of two.
    assign rr_next = ID_WIDTH'((int'(owner_reg) + 1) % NUM_REQ);
    assign rr_base = rr_ptr_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg <= '0;
        end else if (leave_burst) begin
            rr_ptr_reg <= rr_next;
        end
    end
`endif

    // First requester at or after rr_base, wrapping through NUM_REQ-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_WIDTH'((int'(rr_base) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = (state_reg == BURST) && (owner_reg == ID_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
        end else begin
            out_valid_reg <= pop;
            if (pop) begin
                out_data_reg <= fifo_rd_data;
                out_id_reg   <= owner_reg;
            end
            case (state_reg)
                IDLE: begin
                    if (win_found && !fifo_rd_empty) begin
                        owner_reg     <= win_idx;
                        burst_cnt_reg <= '0;
                        state_reg     <= BURST;
                    end
                end
                BURST: begin
                    if (pop) begin
                        burst_cnt_reg <= burst_cnt_reg + CNT_WIDTH'(1);
                    end
                    if (leave_burst) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fifo_rd_ready = pop;
    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;
    assign out_id        = out_id_reg;

endmodule
